// File: rtl/store_queue.sv
// store_queue: age-ordered store buffer with ROB commit, in-order memory drain
// and per-byte store-to-load forwarding.
module store_queue #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 32,
  parameter int TAG_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 st_funct3,
  input  logic [TAG_W-1:0]           st_tag,
  output logic                       st_misalign,
  input  logic                       cm_valid,
  input  logic [TAG_W-1:0]           cm_tag,
  output logic                       cm_error,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [2:0]                 ld_funct3,
  input  logic [TAG_W-1:0]           ld_tag,
  output logic                       ld_resp_valid,
  output logic [31:0]                ld_data,
  output logic [3:0]                 ld_byte_hit,
  output logic                       ld_full_hit,
  output logic                       ld_partial,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_data,
  output logic [3:0]                 mem_be,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR_W-3:0] e_word [DEPTH];
  logic [3:0] e_mask [DEPTH];
  logic [31:0] e_data [DEPTH];
  logic [TAG_W-1:0] e_tag [DEPTH];
  logic [CW-1:0] head, cm_ptr, tail, cm_ptr_n;
  logic [PW-1:0] idx;
  logic mis, do_st, do_cm, do_dr;
  logic [3:0] s_mask, need, hit, hn;
  logic [31:0] s_data, fwd, sh, l_data;
  logic [1:0] lane;
  assign count = tail - head;
  assign empty = count == '0;
  assign st_ready = count < FULL;
  assign mem_valid = head != cm_ptr;
  assign mem_addr = {e_word[head[PW-1:0]], 2'b00};
  assign mem_data = e_data[head[PW-1:0]];
  assign mem_be = e_mask[head[PW-1:0]];
  assign do_cm = cm_valid && cm_ptr != tail && e_tag[cm_ptr[PW-1:0]] == cm_tag;
  assign do_dr = mem_valid && mem_ready;
  assign cm_ptr_n = cm_ptr + CW'(do_cm);
  assign mis = st_funct3 == 3'b001 ? st_addr[0] : st_funct3 == 3'b010 ? st_addr[1:0] != 2'b00 : st_funct3 != 3'b000;
  assign do_st = st_valid && st_ready && !flush && !mis;
  assign s_mask = st_funct3[1] ? 4'b1111 : st_funct3[0] ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << st_addr[1:0];
  assign s_data = st_funct3[1] ? st_data : st_funct3[0] ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
  // Walk oldest to youngest so the youngest older store wins each lane.
  always_comb begin
    fwd = '0;
    hit = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head[PW-1:0] + PW'(k);
      if (CW'(k) < count && e_word[idx] == ld_addr[ADDR_W-1:2] && e_tag[idx] < ld_tag)
        for (int b = 0; b < 4; b++)
          if (e_mask[idx][b]) begin
            fwd[8*b +: 8] = e_data[idx][8*b +: 8];
            hit[b] = 1'b1;
          end
    end
  end
  assign lane = ld_addr[1:0];
  assign need = ld_funct3[1] ? 4'b1111 : ld_funct3[0] ? 4'b0011 << lane : 4'b0001 << lane;
  assign hn = hit & need;
  assign sh = fwd >> {lane, 3'b000};
  assign l_data = ld_funct3[1] ? sh : ld_funct3[0] ? {{16{sh[15] & ~ld_funct3[2]}}, sh[15:0]} : {{24{sh[7] & ~ld_funct3[2]}}, sh[7:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      cm_ptr <= '0;
      tail <= '0;
      st_misalign <= 1'b0;
      cm_error <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_data <= '0;
      ld_byte_hit <= '0;
      ld_full_hit <= 1'b0;
      ld_partial <= 1'b0;
    end else begin
      head <= head + CW'(do_dr);
      cm_ptr <= cm_ptr_n;
      tail <= flush ? cm_ptr_n : tail + CW'(do_st);
      st_misalign <= st_valid && st_ready && !flush && mis;
      cm_error <= cm_valid && !do_cm;
      ld_resp_valid <= ld_valid && !flush;
      ld_byte_hit <= ld_valid ? hn : '0;
      ld_full_hit <= ld_valid && hn == need;
      ld_partial <= ld_valid && hn != '0 && hn != need;
      ld_data <= ld_valid && hn == need ? l_data : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (do_st) begin
      e_word[tail[PW-1:0]] <= st_addr[ADDR_W-1:2];
      e_mask[tail[PW-1:0]] <= s_mask;
      e_data[tail[PW-1:0]] <= s_data;
      e_tag[tail[PW-1:0]] <= st_tag;
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed test-plan sequences plus random traffic checked
// every cycle against a queue-based model of the store queue.
module tb_store_queue;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset, flush, st_valid, st_ready, st_misalign, cm_valid, cm_error;
  logic ld_valid, ld_resp_valid, ld_full_hit, ld_partial, mem_valid, mem_ready, empty;
  logic [31:0] st_addr, st_data, st_tag, cm_tag, ld_addr, ld_tag, ld_data, mem_addr, mem_data;
  logic [2:0] st_funct3, ld_funct3;
  logic [3:0] ld_byte_hit, mem_be;
  logic [4:0] count;
  typedef struct {
    logic [29:0] w;
    logic [3:0] m;
    logic [31:0] d;
    logic [31:0] t;
  } ent_t;
  ent_t q[$];
  int ncm, tests, fails;
  bit run;
  logic x_mis, x_cme, x_rv, x_full, x_part;
  logic [3:0] x_hit;
  logic [31:0] x_data, tagc;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(D), .ADDR_W(32), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3), .st_tag(st_tag), .st_misalign(st_misalign),
    .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_error(cm_error),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_tag(ld_tag),
    .ld_resp_valid(ld_resp_valid), .ld_data(ld_data), .ld_byte_hit(ld_byte_hit),
    .ld_full_hit(ld_full_hit), .ld_partial(ld_partial),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_be(mem_be), .count(count), .empty(empty)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic ent_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input logic [31:0] t);
    ent_t e;
    e.w = a[31:2];
    e.t = t;
    case (f)
      3'd0: begin e.m = 4'b0001 << a[1:0]; e.d = {4{d[7:0]}}; end
      3'd1: begin e.m = a[1] ? 4'b1100 : 4'b0011; e.d = {2{d[15:0]}}; end
      default: begin e.m = 4'b1111; e.d = d; end
    endcase
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model();
    logic [3:0] need, hit;
    logic [31:0] w, v;
    int lane, nb;
    logic ok, dr, rdy, mis;
    if (reset) begin
      q.delete();
      ncm = 0;
      {x_mis, x_cme, x_rv, x_full, x_part} = '0;
      x_hit = '0;
      x_data = '0;
      return;
    end
    lane = int'(ld_addr[1:0]);
    nb = ld_funct3[1] ? 4 : ld_funct3[0] ? 2 : 1;
    need = '0;
    for (int b = 0; b < 4; b++) if (ld_funct3[1] || (b >= lane && b < lane + nb)) need[b] = 1'b1;
    hit = '0;
    w = '0;
    for (int b = 0; b < 4; b++)
      if (need[b])
        for (int k = q.size() - 1; k >= 0; k--)
          if (q[k].w == ld_addr[31:2] && q[k].t < ld_tag && q[k].m[b]) begin
            hit[b] = 1'b1;
            w[8*b +: 8] = q[k].d[8*b +: 8];
            break;
          end
    v = w >> (8 * lane);
    case (ld_funct3)
      3'd0: v = {{24{v[7]}}, v[7:0]};
      3'd1: v = {{16{v[15]}}, v[15:0]};
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: ;
    endcase
    x_rv = ld_valid && !flush;
    x_hit = ld_valid ? hit : 4'h0;
    x_full = ld_valid && hit == need;
    x_part = ld_valid && hit != 0 && hit != need;
    x_data = (ld_valid && hit == need) ? v : 32'h0;
    ok = cm_valid && ncm < q.size() && q[ncm].t == cm_tag;
    x_cme = cm_valid && !ok;
    dr = ncm > 0 && mem_ready;
    rdy = q.size() < D;
    mis = !(st_funct3 == 0 || (st_funct3 == 1 && !st_addr[0]) || (st_funct3 == 2 && st_addr[1:0] == 0));
    x_mis = st_valid && rdy && !flush && mis;
    if (ok) ncm++;
    if (dr) begin
      q.delete(0);
      ncm--;
    end
    if (st_valid && rdy && !flush && !mis) q.push_back(mk(st_funct3, st_addr, st_data, st_tag));
    if (flush) while (q.size() > ncm) q.delete(q.size() - 1);
  endtask

  always @(negedge clk) if (run) begin
    chk("count", 32'(count), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(q.size() < D));
    chk("mem_valid", 32'(mem_valid), 32'(ncm > 0));
    if (ncm > 0) begin
      chk("mem_addr", mem_addr, {q[0].w, 2'b00});
      chk("mem_data", mem_data, q[0].d);
      chk("mem_be", 32'(mem_be), 32'(q[0].m));
    end
    chk("st_misalign", 32'(st_misalign), 32'(x_mis));
    chk("cm_error", 32'(cm_error), 32'(x_cme));
    chk("ld_resp_valid", 32'(ld_resp_valid), 32'(x_rv));
    if (x_rv) begin
      chk("ld_data", ld_data, x_data);
      chk("ld_byte_hit", 32'(ld_byte_hit), 32'(x_hit));
      chk("ld_full_hit", 32'(ld_full_hit), 32'(x_full));
      chk("ld_partial", 32'(ld_partial), 32'(x_part));
    end
  end

  task automatic idle();
    {reset, flush, st_valid, cm_valid, ld_valid, mem_ready} = '0;
    st_addr = '0; st_data = '0; st_funct3 = '0; st_tag = '0;
    cm_tag = '0; ld_addr = '0; ld_funct3 = '0; ld_tag = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    model();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rst();
    reset = 1'b1;
    cyc();
  endtask

  task automatic st(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input logic [31:0] t);
    st_valid = 1'b1; st_funct3 = f; st_addr = a; st_data = d; st_tag = t;
    cyc();
  endtask

  task automatic ld(input logic [2:0] f, input logic [31:0] a, input logic [31:0] t);
    ld_valid = 1'b1; ld_funct3 = f; ld_addr = a; ld_tag = t;
    cyc();
  endtask

  task automatic cm(input logic [31:0] t);
    cm_valid = 1'b1; cm_tag = t;
    cyc();
  endtask

  initial begin
    idle();
    tests = 0; fails = 0; ncm = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b1;
    rst();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    st(3'd2, 32'h100, 32'hDEADBEEF, 5);
    ld(3'd2, 32'h100, 6);
    chk("lw_full_hit", 32'(ld_full_hit), 1);
    chk("lw_data", ld_data, 32'hDEADBEEF);
    ld(3'd2, 32'h100, 4);
    chk("lw_old_hit", 32'(ld_byte_hit), 0);
    rst();
    st(3'd0, 32'h201, 32'h7F, 1);
    st(3'd2, 32'h200, 32'h11223344, 2);
    st(3'd0, 32'h202, 32'h80, 3);
    ld(3'd2, 32'h200, 9);
    chk("merge_data", ld_data, 32'h11803344);
    chk("merge_full", 32'(ld_full_hit), 1);
    ld(3'd0, 32'h202, 9);
    chk("lb_sext", ld_data, 32'hFFFFFF80);
    rst();
    st(3'd1, 32'h302, 32'hABCD, 1);
    ld(3'd2, 32'h300, 2);
    chk("part_hit", 32'(ld_byte_hit), 32'hC);
    chk("part_flag", 32'(ld_partial), 1);
    chk("part_data", ld_data, 0);
    rst();
    for (int i = 0; i < D; i++) st(3'd2, 32'h400 + 32'(4 * i), 32'(i), 32'(i + 1));
    chk("full_count", 32'(count), D);
    chk("full_ready", 32'(st_ready), 0);
    cm(1);
    cm(2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_addr", mem_addr, 32'h400);
      chk("stall_data", mem_data, 0);
    end
    mem_ready = 1'b1; cyc();
    mem_ready = 1'b1; cyc();
    chk("drain_count", 32'(count), D - 2);
    st(3'd2, 32'h480, 32'hA, 17);
    st(3'd2, 32'h484, 32'hB, 18);
    chk("refill_count", 32'(count), D);
    cm(3);
    mem_ready = 1'b1;
    st(3'd2, 32'h488, 32'hC, 19);
    chk("full_drain_noenq", 32'(count), D - 1);
    rst();
    for (int i = 0; i < 4; i++) st(3'd2, 32'h500 + 32'(4 * i), 32'(i), 32'(10 + i));
    cm(10);
    cm(11);
    flush = 1'b1; cyc();
    chk("flush_count", 32'(count), 2);
    mem_ready = 1'b1; cyc();
    mem_ready = 1'b1; cyc();
    chk("flush_drained", 32'(empty), 1);
    cm(12);
    chk("cm_err_pulse", 32'(cm_error), 1);
    st(3'd2, 32'h102, 32'h1, 50);
    chk("misalign_pulse", 32'(st_misalign), 1);
    chk("misalign_count", 32'(count), 0);
    for (int i = 0; i < 3; i++) st(3'd2, 32'h600 + 32'(4 * i), 32'(i), 32'(60 + i));
    cm(60);
    cm(61);
    mem_ready = 1'b1; cyc();
    mem_ready = 1'b1; reset = 1'b1; cyc();
    chk("rst_mid_valid", 32'(mem_valid), 0);
    chk("rst_mid_count", 32'(count), 0);
    tagc = 1000;
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] sl;
      reset = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 24) == 0;
      mem_ready = $urandom_range(0, 1);
      st_valid = $urandom_range(0, 1);
      st_funct3 = $urandom_range(0, 15) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      sl = 2'($urandom);
      if ($urandom_range(0, 7) != 0) sl = st_funct3 == 1 ? (sl & 2'b10) : st_funct3 == 2 ? 2'b00 : sl;
      st_addr = 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'(sl);
      st_data = $urandom;
      st_tag = tagc;
      tagc++;
      ld_valid = $urandom_range(0, 9) < 6;
      case ($urandom_range(0, 4))
        0: ld_funct3 = 3'd0;
        1: ld_funct3 = 3'd1;
        2: ld_funct3 = 3'd2;
        3: ld_funct3 = 3'd4;
        default: ld_funct3 = 3'd5;
      endcase
      sl = 2'($urandom);
      sl = ld_funct3[1] ? 2'b00 : ld_funct3[0] ? (sl & 2'b10) : sl;
      ld_addr = 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'(sl);
      ld_tag = tagc - 32'($urandom_range(0, 6));
      cm_valid = $urandom_range(0, 9) < 4;
      cm_tag = (ncm < q.size() && $urandom_range(0, 9) != 0) ? q[ncm].t : $urandom;
      cyc();
    end
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
